serial_capture: RTL and testbench



---
 rtl/serial_capture.sv | 171 +++++++++++++++++
 tb/tb_serial_capture.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/serial_capture.sv
// serial_capture: receive side of the LED-board serial chain.
// Deserialises the sclk/sdi/lat stream into channel words, writes each word
// to a frame-buffer RAM write port and checks the frame length at every latch.
// Optional build macro SERIAL_CAPTURE_ADDR_REMAP_EN: reverse the address order
// inside each 16-channel group. Without it, words are stored in arrival order.
`timescale 1ns/1ps
module serial_capture #(
  parameter int c_ledboards   = 30,
  parameter int c_channels    = c_ledboards * 32,
  parameter int c_addr_w      = $clog2(c_channels),
  parameter int c_bpc         = 12,
  parameter int c_frame_cnt_w = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_sclk,
  input  logic                     i_sdi,
  input  logic                     i_lat,
  output logic                     o_wr_en,
  output logic [c_addr_w-1:0]      o_wr_addr,
  output logic [c_bpc-1:0]         o_wr_data,
  output logic                     o_busy,
  output logic                     o_frame_done,
  output logic                     o_frame_err,
  output logic [c_frame_cnt_w-1:0] o_frame_cnt
);

  // Word counter needs one extra bit to hold the value c_channels.
  localparam int c_word_w = c_addr_w + 1;
  localparam int c_bit_w  = $clog2(c_bpc);
  localparam logic [c_word_w-1:0] c_full     = c_word_w'(c_channels);
  localparam logic [c_bit_w-1:0]  c_last_bit = c_bit_w'(c_bpc - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SHIFT   = 2'd1;
  localparam logic [1:0] S_OVERRUN = 2'd2;

  logic [2:0]               sclk_sync_q;
  logic [1:0]               sdi_sync_q;
  logic [2:0]               lat_sync_q;
  logic [1:0]               state_q, state_d;
  logic [c_bpc-1:0]         sr_q, sr_d;
  logic [c_bit_w-1:0]       bit_q, bit_d;
  logic [c_word_w-1:0]      word_q, word_d;
  logic                     pend_q, pend_d;
  logic                     wr_en_q;
  logic [c_addr_w-1:0]      wr_addr_q, wr_addr_d;
  logic [c_bpc-1:0]         wr_data_q, wr_data_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;
  logic [c_frame_cnt_w-1:0] cnt_q, cnt_d;
  logic [c_bpc-1:0]         shifted;
  logic                     sclk_rise;
  logic                     lat_rise;
  logic                     sdi_s;

  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign lat_rise  = lat_sync_q[1] & ~lat_sync_q[2];
  // Data taken from its 2nd stage lines up with the sclk edge detect.
  assign sdi_s     = sdi_sync_q[1];

  // Buffer address for the k-th received word of the frame.
  function automatic logic [c_addr_w-1:0] map_addr(input logic [c_addr_w-1:0] k);
`ifdef SERIAL_CAPTURE_ADDR_REMAP_EN
    // Group base kept, 15 - (k mod 16) is the bitwise inverse of the low nibble.
    return {k[c_addr_w-1:4], ~k[3:0]};
`else
    return k;
`endif
  endfunction

  // Next-state logic: bit/word assembly first, then the latch check on the
  // updated counters so a coincident final bit still counts toward the frame.
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    bit_d     = bit_q;
    word_d    = word_q;
    pend_d    = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    cnt_d     = cnt_q;
    shifted   = {sr_q[c_bpc-2:0], sdi_s};

    if (sclk_rise) begin
      case (state_q)
        S_IDLE: begin
          sr_d    = shifted;
          bit_d   = c_bit_w'(1);
          state_d = S_SHIFT;
        end
        S_SHIFT: begin
          if (word_q == c_full) begin
            state_d = S_OVERRUN;
          end else begin
            sr_d = shifted;
            if (bit_q == c_last_bit) begin
              bit_d     = '0;
              word_d    = word_q + c_word_w'(1);
              pend_d    = 1'b1;
              wr_addr_d = map_addr(word_q[c_addr_w-1:0]);
              wr_data_d = shifted;
            end else begin
              bit_d = bit_q + c_bit_w'(1);
            end
          end
        end
        default: ;
      endcase
    end

    if (lat_rise) begin
      if (state_d == S_SHIFT && word_d == c_full && bit_d == '0) begin
        done_d = 1'b1;
        cnt_d  = cnt_q + c_frame_cnt_w'(1);
      end else begin
        err_d = 1'b1;
      end
      state_d = S_IDLE;
      bit_d   = '0;
      word_d  = '0;
      sr_d    = '0;
    end
  end

  // Synchronisers, FSM state and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sclk_sync_q <= '0;
      sdi_sync_q  <= '0;
      lat_sync_q  <= '0;
      state_q     <= S_IDLE;
      sr_q        <= '0;
      bit_q       <= '0;
      word_q      <= '0;
      pend_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[1:0], i_sclk};
      sdi_sync_q  <= {sdi_sync_q[0], i_sdi};
      lat_sync_q  <= {lat_sync_q[1:0], i_lat};
      state_q     <= state_d;
      sr_q        <= sr_d;
      bit_q       <= bit_d;
      word_q      <= word_d;
      pend_q      <= pend_d;
      wr_en_q     <= pend_q;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign o_wr_en      = wr_en_q;
  assign o_wr_addr    = wr_addr_q;
  assign o_wr_data    = wr_data_q;
  assign o_busy       = (state_q != S_IDLE);
  assign o_frame_done = done_q;
  assign o_frame_err  = err_q;
  assign o_frame_cnt  = cnt_q;

endmodule

// File: tb/tb_serial_capture.sv
// Bench for serial_capture with a one-board (32-channel) chain.
// Stimulus pushes expected writes and frame events into queues; a monitor
// pops and compares whenever the DUT presents a write or a frame pulse.
`timescale 1ns/1ps
module tb_serial_capture;
  localparam int NB  = 1;
  localparam int NCH = 32;
  localparam int AW  = 5;
  localparam int BPC = 12;
  localparam int FW  = 16;

  logic          clk = 1'b0;
  logic          rst, sclk, sdi, lat;
  logic          wr_en, busy, frame_done, frame_err;
  logic [AW-1:0] wr_addr;
  logic [BPC-1:0] wr_data;
  logic [FW-1:0] frame_cnt;

  always #5 clk = ~clk;

  serial_capture #(.c_ledboards(NB)) dut (
    .i_clk(clk), .i_rst(rst), .i_sclk(sclk), .i_sdi(sdi), .i_lat(lat),
    .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data), .o_busy(busy),
    .o_frame_done(frame_done), .o_frame_err(frame_err), .o_frame_cnt(frame_cnt)
  );

  int checks = 0;
  int errors = 0;
  logic [AW+BPC-1:0] exp_wr[$];
  int exp_ev[$];          // 1 = frame_done, 2 = frame_err
  int exp_cnt = 0;

  function automatic int map_exp(int k);
`ifdef SERIAL_CAPTURE_ADDR_REMAP_EN
    return (k / 16) * 16 + 15 - (k % 16);
`else
    return k;
`endif
  endfunction

  function automatic logic [BPC-1:0] pat(int k, int p);
    int v;
    if (p == 0) v = k;
    else v = ((k * 'h155) ^ 'hA5A) & 'hFFF;
    return BPC'(v);
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: compare every write and frame pulse against the scoreboard.
  always @(negedge clk) begin : monitor
    logic [AW+BPC-1:0] e;
    if (wr_en) begin
      if (exp_wr.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write addr=%0h data=%0h required=none", wr_addr, wr_data);
      end else begin
        e = exp_wr.pop_front();
        chk("wr_addr", int'(wr_addr), int'(e[AW+BPC-1:BPC]));
        chk("wr_data", int'(wr_data), int'(e[BPC-1:0]));
        $display("write addr=%0d data=%03h", wr_addr, wr_data);
      end
    end
    if (frame_done && frame_err) begin
      checks++; errors++;
      $display("FAIL done_and_err actual=both required=one");
    end else if (frame_done || frame_err) begin
      if (exp_ev.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_event actual=%0d required=none", frame_done ? 1 : 2);
      end else begin
        chk("frame_event", frame_done ? 1 : 2, exp_ev.pop_front());
        $display("frame event %s cnt=%0d", frame_done ? "done" : "err", frame_cnt);
      end
    end
  end

  task automatic send_bit(input logic b, input bit lat_chk, input bit with_lat);
    @(negedge clk); sdi = b;
    repeat (2) @(negedge clk);
    sclk = 1'b1;
    if (with_lat) lat = 1'b1;
    repeat (3) @(negedge clk);
    if (lat_chk) chk("wr_latency_pre", int'(wr_en), 0);
    sclk = 1'b0;
    lat  = 1'b0;
    @(negedge clk);
    if (lat_chk) chk("wr_latency", int'(wr_en), 1);
  endtask

  task automatic send_word(input int idx, input logic [BPC-1:0] w,
                           input bit lat_chk, input bit lat_on_last);
    if (idx < NCH) exp_wr.push_back({AW'(map_exp(idx)), w});
    for (int i = BPC - 1; i >= 0; i--)
      send_bit(w[i], lat_chk && (i == 0), lat_on_last && (i == 0));
  endtask

  task automatic send_frame(input int n, input int p, input bit lat_chk);
    for (int k = 0; k < n; k++) send_word(k, pat(k, p), lat_chk && (k == 0), 1'b0);
  endtask

  task automatic do_latch();
    repeat (3) @(negedge clk); lat = 1'b1;
    repeat (3) @(negedge clk); lat = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic end_check();
    repeat (8) @(negedge clk);
    chk("wr_queue_empty", exp_wr.size(), 0);
    chk("event_queue_empty", exp_ev.size(), 0);
    chk("frame_cnt", int'(frame_cnt), exp_cnt);
    chk("busy_after", int'(busy), 0);
  endtask

  task automatic chk_zero_outputs();
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_wr_data", int'(wr_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(frame_done), 0);
    chk("rst_err", int'(frame_err), 0);
    chk("rst_cnt", int'(frame_cnt), 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; sclk = 1'b0; sdi = 1'b0; lat = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero_outputs();
    rst = 1'b0;

    // Full frame of words 0..31, with write-latency check on word 0.
    send_frame(NCH, 0, 1'b1);
    chk("busy_mid", int'(busy), 1);
    exp_ev.push_back(1); exp_cnt++;
    do_latch();
    end_check();

    // Short frame: 31 words plus 5 bits.
    send_frame(NCH - 1, 1, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0, 1'b0);
    exp_ev.push_back(2);
    do_latch();
    end_check();

    // Long frame: 33 words, only 32 written; then a good frame.
    send_frame(NCH + 1, 1, 1'b0);
    exp_ev.push_back(2);
    do_latch();
    end_check();
    send_frame(NCH, 1, 1'b0);
    exp_ev.push_back(1); exp_cnt++;
    do_latch();
    end_check();

    // Reset after 10 words abandons the frame silently.
    send_frame(10, 0, 1'b0);
    repeat (6) @(negedge clk);
    chk("pre_rst_queue", exp_wr.size(), 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_zero_outputs();
    exp_cnt = 0;
    send_frame(NCH, 0, 1'b0);
    exp_ev.push_back(1); exp_cnt++;
    do_latch();
    end_check();

    // Final sclk rise coincident with latch rise.
    send_frame(NCH - 1, 1, 1'b0);
    exp_ev.push_back(1); exp_cnt++;
    send_word(NCH - 1, pat(NCH - 1, 1), 1'b0, 1'b1);
    end_check();

    // Latch in idle with no bits.
    exp_ev.push_back(2);
    do_latch();
    end_check();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
